// File: rtl/knn_vote_pkg.sv
// Shared defaults and FSM encoding for the knn_vote majority-vote classifier.
package knn_vote_pkg;

    localparam int KNN_LABEL_W      = 8;
    localparam int KNN_K_NEIGHBOURS = 10;
    localparam int KNN_CNT_W        = $clog2(KNN_K_NEIGHBOURS + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_COUNT = 2'd1,
        ST_DONE  = 2'd2
    } knn_state_e;

endpackage

// File: rtl/knn_label_match_count.sv
// Combinational popcount of valid neighbour slots whose label equals ref_lbl.
module knn_label_match_count #(
    parameter int LABEL_W      = 8,
    parameter int K_NEIGHBOURS = 10,
    parameter int CNT_W        = $clog2(K_NEIGHBOURS + 1)
) (
    input  logic [LABEL_W*K_NEIGHBOURS-1:0] labels,
    input  logic [LABEL_W-1:0]              ref_lbl,
    input  logic [CNT_W-1:0]                nv,
    output logic [CNT_W-1:0]                cnt
);

    always_comb begin
        cnt = '0;
        for (int j = 0; j < K_NEIGHBOURS; j++) begin
            // Slots at or beyond nv are stale and must never vote.
            if ((j < int'(nv)) && (labels[j*LABEL_W +: LABEL_W] == ref_lbl)) begin
                cnt = cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/knn_vote.sv
// Sequential K-nearest-neighbour majority vote; ties go to the nearest neighbour's class.
// Optional statistics outputs (vote_count, unanimous) are enabled by defining KNN_VOTE_STATS_EN.
module knn_vote
    import knn_vote_pkg::*;
#(
    parameter int LABEL_W      = KNN_LABEL_W,
    parameter int K_NEIGHBOURS = KNN_K_NEIGHBOURS,
    localparam int CNT_W       = $clog2(K_NEIGHBOURS + 1)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            start,
    input  logic [CNT_W-1:0]                n_valid,
    input  logic [LABEL_W*K_NEIGHBOURS-1:0] labels,
    output logic                            busy,
    output logic                            done,
    output logic [LABEL_W-1:0]              class_out,
`ifdef KNN_VOTE_STATS_EN
    output logic [CNT_W-1:0]                vote_count,
    output logic                            unanimous,
`endif
    output logic                            empty
);

    // Handshake: start is a one-cycle request honoured only in IDLE; done is a
    // one-cycle pulse, and class_out/empty stay stable until the next done.

    localparam logic [CNT_W-1:0] K_CNT = CNT_W'(K_NEIGHBOURS);

    knn_state_e                      state_q, state_d;
    logic [LABEL_W*K_NEIGHBOURS-1:0] label_q;
    logic [CNT_W-1:0]                nv_q, nv_clamped, idx, best_cnt, cnt;
    logic [LABEL_W-1:0]              best_lbl, ref_lbl;
    logic                            last_idx;

    assign nv_clamped = (n_valid > K_CNT) ? K_CNT : n_valid;
    assign last_idx   = (idx == nv_q - CNT_W'(1));

    always_comb begin
        ref_lbl = '0;
        for (int i = 0; i < K_NEIGHBOURS; i++) begin
            if (idx == CNT_W'(i)) ref_lbl = label_q[i*LABEL_W +: LABEL_W];
        end
    end

    knn_label_match_count #(
        .LABEL_W      (LABEL_W),
        .K_NEIGHBOURS (K_NEIGHBOURS),
        .CNT_W        (CNT_W)
    ) u_match (
        .labels  (label_q),
        .ref_lbl (ref_lbl),
        .nv      (nv_q),
        .cnt     (cnt)
    );

    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start) state_d = (nv_clamped == '0) ? ST_DONE : ST_COUNT;
            ST_COUNT: if (last_idx) state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q == ST_COUNT) || (state_q == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            label_q    <= '0;
            nv_q       <= '0;
            idx        <= '0;
            best_cnt   <= '0;
            best_lbl   <= '0;
            done       <= 1'b0;
            class_out  <= '0;
            empty      <= 1'b0;
`ifdef KNN_VOTE_STATS_EN
            vote_count <= '0;
            unanimous  <= 1'b0;
`endif
        end else begin
            done <= (state_q == ST_DONE);
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        label_q  <= labels;
                        nv_q     <= nv_clamped;
                        idx      <= '0;
                        best_cnt <= '0;
                        best_lbl <= '0;
                    end
                end
                ST_COUNT: begin
                    // Strict compare keeps the earliest (nearest) class on a tie.
                    if (cnt > best_cnt) begin
                        best_cnt <= cnt;
                        best_lbl <= ref_lbl;
                    end
                    if (!last_idx) idx <= idx + CNT_W'(1);
                end
                ST_DONE: begin
                    class_out  <= best_lbl;
                    empty      <= (nv_q == '0);
`ifdef KNN_VOTE_STATS_EN
                    vote_count <= best_cnt;
                    unanimous  <= (best_cnt == nv_q) && (nv_q != '0);
`endif
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_knn_vote.sv
// Self-checking bench for knn_vote: directed plan cases plus randomized votes vs a tally model.
module tb_knn_vote;

    localparam int LW = 8;
    localparam int K  = 10;
    localparam int CW = $clog2(K + 1);

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [CW-1:0]     n_valid;
    logic [LW*K-1:0]   labels;
    logic              busy, done, empty;
    logic [LW-1:0]     class_out;
`ifdef KNN_VOTE_STATS_EN
    logic [CW-1:0]     vote_count;
    logic              unanimous;
`endif

    int n_checks = 0;
    int n_fails  = 0;
    logic [LW-1:0] exp_q[$];

    knn_vote dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .n_valid    (n_valid),
        .labels     (labels),
        .busy       (busy),
        .done       (done),
        .class_out  (class_out),
`ifdef KNN_VOTE_STATS_EN
        .vote_count (vote_count),
        .unanimous  (unanimous),
`endif
        .empty      (empty)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // Tally every valid label, find the top count, then pick the nearest slot holding it.
    function automatic logic [LW-1:0] model_class(input logic [LW-1:0] lab[K], input int nv,
                                                  output int votes);
        int tally[int];
        int top = 0;
        logic [LW-1:0] win = '0;
        for (int j = 0; j < nv; j++) begin
            if (tally.exists(int'(lab[j]))) tally[int'(lab[j])] += 1;
            else tally[int'(lab[j])] = 1;
        end
        foreach (tally[c]) if (tally[c] > top) top = tally[c];
        for (int i = nv - 1; i >= 0; i--) if (tally[int'(lab[i])] == top) win = lab[i];
        votes = top;
        return win;
    endfunction

    // ---------------- driver ----------------
    task automatic drive_bus(input logic [LW-1:0] lab[K], input int nv);
        for (int i = 0; i < K; i++) labels[i*LW +: LW] = lab[i];
        n_valid = CW'(nv);
    endtask

    task automatic scramble_inputs();
        for (int i = 0; i < K; i++) labels[i*LW +: LW] = LW'($urandom);
        n_valid = CW'($urandom);
    endtask

    task automatic run_classify(input logic [LW-1:0] lab[K], input int nv, input string tag);
        int nvc, votes, cyc;
        bit got;
        logic [LW-1:0] exp_cls;
        nvc = (nv > K) ? K : nv;
        exp_cls = model_class(lab, nvc, votes);
        drive_bus(lab, nv);
        start = 1'b1;
        step();
        start = 1'b0;
        scramble_inputs();
        exp_q.push_back(exp_cls);
        check({tag, "_busy"}, 32'(busy), 32'd1);
        cyc = 0;
        got = 1'b0;
        while (cyc < 40 && !got) begin
            step();
            cyc++;
            if (done) got = 1'b1;
        end
        check({tag, "_done_seen"}, 32'(got), 32'd1);
        check({tag, "_latency"}, 32'(cyc), 32'(nvc + 1));
        check({tag, "_class"}, 32'(class_out), 32'(exp_q.pop_front()));
        check({tag, "_empty"}, 32'(empty), 32'(nvc == 0));
`ifdef KNN_VOTE_STATS_EN
        check({tag, "_votes"}, 32'(vote_count), 32'(votes));
        check({tag, "_unanimous"}, 32'(unanimous), 32'((votes == nvc) && (nvc != 0)));
`endif
        step();
        check({tag, "_done_pulse"}, 32'(done), 32'd0);
        check({tag, "_idle"}, 32'(busy), 32'd0);
        check({tag, "_hold"}, 32'(class_out), 32'(exp_cls));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [LW-1:0] lab[K];
        int dummy, pulses;
        logic [LW-1:0] exp_cls;

        rst = 1'b1;
        start = 1'b0;
        n_valid = '0;
        labels = '0;
        repeat (3) step();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_class", 32'(class_out), 32'd0);
        check("rst_empty", 32'(empty), 32'd0);
        rst = 1'b0;
        step();

        // All labels identical.
        for (int i = 0; i < K; i++) lab[i] = 8'h05;
        run_classify(lab, 10, "all05");
        check("all05_direct", 32'(class_out), 32'h05);

        // Clear majority.
        lab = '{8'd3, 8'd7, 8'd7, 8'd3, 8'd7, 8'd1, 8'd1, 8'd1, 8'd7, 8'd2};
        run_classify(lab, 10, "major");
        check("major_direct", 32'(class_out), 32'h07);

        // Tie resolves to nearest.
        lab = '{8'd4, 8'd9, 8'd9, 8'd4, 8'd9, 8'd9, 8'd9, 8'd9, 8'd9, 8'd9};
        run_classify(lab, 4, "tie");
        check("tie_direct", 32'(class_out), 32'h04);

        // Empty neighbour set.
        run_classify(lab, 0, "nv0");
        check("nv0_direct", 32'(class_out), 32'h00);

        // Slots beyond n_valid must not vote.
        for (int i = 0; i < K; i++) lab[i] = 8'hAA;
        lab[0] = 8'd1; lab[1] = 8'd2; lab[2] = 8'd2;
        run_classify(lab, 3, "nv3");
        check("nv3_direct", 32'(class_out), 32'h02);

        // n_valid above K clamps.
        run_classify(lab, 15, "clamp");

        // Second start during COUNT is ignored.
        lab = '{8'd3, 8'd7, 8'd7, 8'd3, 8'd7, 8'd1, 8'd1, 8'd1, 8'd7, 8'd2};
        exp_cls = model_class(lab, 10, dummy);
        drive_bus(lab, 10);
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (3) step();
        for (int i = 0; i < K; i++) labels[i*LW +: LW] = 8'd1;
        n_valid = CW'(2);
        start = 1'b1;
        step();
        start = 1'b0;
        pulses = 0;
        for (int c = 0; c < 30; c++) begin
            step();
            if (done) pulses++;
        end
        check("dbl_start_pulses", 32'(pulses), 32'd1);
        check("dbl_start_class", 32'(class_out), 32'(exp_cls));

        // Reset in COUNT aborts without a done pulse.
        drive_bus(lab, 10);
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (4) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_class", 32'(class_out), 32'd0);
        pulses = 0;
        for (int c = 0; c < 15; c++) begin
            if (done) pulses++;
            step();
        end
        check("abort_no_done", 32'(pulses), 32'd0);
        run_classify(lab, 10, "after_abort");

        // Randomized votes over small alphabets to force ties.
        for (int r = 0; r < 40; r++) begin
            int alpha;
            alpha = (r % 4 == 0) ? 255 : $urandom_range(1, 4);
            for (int i = 0; i < K; i++) lab[i] = LW'($urandom_range(0, alpha));
            run_classify(lab, $urandom_range(0, 15), $sformatf("rand%0d", r));
            repeat ($urandom_range(0, 2)) step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
